// File: rtl/udp_stream_pkg.sv
// Shared definitions for the UDP byte-stream blocks: parameter defaults and FSM encodings.
// S_HDR exists only when UDP_TX_ARB_HDR_EN is defined.
package udp_stream_pkg;

    localparam int         SRC_NUM_DEF  = 4;
    localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

`ifdef UDP_TX_ARB_HDR_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PASS = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/udp_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after 'last',
// wrapping modulo N, returned as one-hot grant plus binary index.
module udp_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(last) + i) % N]) begin
                any                           = 1'b1;
                idx                           = IW'((int'(last) + i) % N);
                grant[(int'(last) + i) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging SRC_NUM byte streams onto one registered TX stream.
// Define UDP_TX_ARB_HDR_EN to prefix every packet with the byte HDR_BASE|source_index.
module udp_tx_arbiter
    import udp_stream_pkg::*;
#(
    parameter int         SRC_NUM  = SRC_NUM_DEF,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [SRC_NUM*8-1:0] i_src_tdata,
    input  logic [SRC_NUM-1:0]   i_src_tvalid,
    input  logic [SRC_NUM-1:0]   i_src_tlast,
    output logic [SRC_NUM-1:0]   o_src_tready,
    output logic [7:0]           o_tx_tdata,
    output logic                 o_tx_tvalid,
    output logic                 o_tx_tlast,
    input  logic                 i_tx_tready,
    output logic [SRC_NUM-1:0]   o_grant,
    output logic                 o_busy
);

    localparam int IW = $clog2(SRC_NUM);

    state_t             state;
    logic [SRC_NUM-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      last_idx;

    logic [SRC_NUM-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic               out_ready;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic               accept;

    udp_rr_pick #(.N(SRC_NUM), .IW(IW)) u_pick (
        .req   (i_src_tvalid),
        .last  (last_idx),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The output register can take a new byte when empty or being drained this cycle.
    assign out_ready = !o_tx_tvalid || i_tx_tready;
    assign sel_valid = i_src_tvalid[grant_idx];
    assign sel_last  = i_src_tlast[grant_idx];
    assign sel_data  = i_src_tdata[8*int'(grant_idx) +: 8];
    assign accept    = (state == S_PASS) && sel_valid && out_ready;

    assign o_src_tready = grant & {SRC_NUM{(state == S_PASS) && out_ready}};
    assign o_grant      = grant;
    assign o_busy       = (state != S_IDLE) || o_tx_tvalid;

`ifndef UDP_TX_ARB_HDR_EN
    logic unused_hdr_base;
    assign unused_hdr_base = ^HDR_BASE;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            last_idx    <= IW'(SRC_NUM - 1);
            o_tx_tdata  <= '0;
            o_tx_tvalid <= 1'b0;
            o_tx_tlast  <= 1'b0;
        end else begin
            // NOTE: state lives in non-blocking assignments; the later load below overrides this drain default.
            if (out_ready) begin
                o_tx_tvalid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        grant     <= pick_grant;
                        grant_idx <= pick_idx;
`ifdef UDP_TX_ARB_HDR_EN
                        state     <= S_HDR;
`else
                        state     <= S_PASS;
`endif
                    end
                end
`ifdef UDP_TX_ARB_HDR_EN
                S_HDR: begin
                    if (out_ready) begin
                        o_tx_tdata  <= HDR_BASE | 8'(grant_idx);
                        o_tx_tlast  <= 1'b0;
                        o_tx_tvalid <= 1'b1;
                        state       <= S_PASS;
                    end
                end
`endif
                S_PASS: begin
                    if (accept) begin
                        o_tx_tdata  <= sel_data;
                        o_tx_tlast  <= sel_last;
                        o_tx_tvalid <= 1'b1;
                        if (sel_last) begin
                            last_idx <= grant_idx;
                            grant    <= '0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: drivers push expected beats, a negedge monitor pops and compares.
// Expected streams include the header byte when UDP_TX_ARB_HDR_EN is defined.
module tb_udp_tx_arbiter;
    import udp_stream_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*8-1:0] src_tdata;
    logic [N-1:0]   src_tvalid;
    logic [N-1:0]   src_tlast;
    logic [N-1:0]   src_tready;
    logic [7:0]     tx_tdata;
    logic           tx_tvalid;
    logic           tx_tlast;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    logic [7:0] src_data  [N];
    logic       src_valid [N];
    logic       src_last  [N];

    logic [7:0] pkt_bytes [N][8];
    int         pkt_len   [N];
    int         gap_at    [N];
    int         gap_len   [N];
    int         abort_after [N];

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic       held_valid = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_src
        assign src_tdata[8*k +: 8] = src_data[k];
        assign src_tvalid[k]       = src_valid[k];
        assign src_tlast[k]        = src_last[k];
    end

    udp_tx_arbiter #(.SRC_NUM(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_src_tdata  (src_tdata),
        .i_src_tvalid (src_tvalid),
        .i_src_tlast  (src_tlast),
        .o_src_tready (src_tready),
        .o_tx_tdata   (tx_tdata),
        .o_tx_tvalid  (tx_tvalid),
        .o_tx_tlast   (tx_tlast),
        .i_tx_tready  (tx_ready),
        .o_grant      (grant),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int src);
        exp_t e;
`ifdef UDP_TX_ARB_HDR_EN
        e.data = HDR_BASE_DEF | 8'(src);
        e.last = 1'b0;
        exp_q.push_back(e);
`endif
        for (int i = 0; i < pkt_len[src]; i++) begin
            e.data = pkt_bytes[src][i];
            e.last = (i == pkt_len[src] - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_valid[k]   = 1'b0;
            src_last[k]    = 1'b0;
            src_data[k]    = 8'h00;
            gap_at[k]      = -1;
            gap_len[k]     = 0;
            abort_after[k] = -1;
        end
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one packet from a source; checks grant at each acceptance and the one-cycle output latency.
    task automatic run_src(input int src);
        int waited;
        bit accepted;
        for (int i = 0; i < pkt_len[src]; i++) begin
            src_data[src]  = pkt_bytes[src][i];
            src_last[src]  = (i == pkt_len[src] - 1);
            src_valid[src] = 1'b1;
            waited   = 0;
            accepted = 1'b0;
            while (!accepted) begin
                @(negedge clk);
                if (src_tready[src]) begin
                    accepted = 1'b1;
                end else if (++waited > 200) begin
                    errors++;
                    checks++;
                    $display("FAIL src%0d_timeout: byte %0d never accepted", src, i);
                    src_valid[src] = 1'b0;
                    return;
                end
            end
            check($sformatf("grant_src%0d", src), 32'(grant), 32'(1 << src));
            @(posedge clk);
            #1;
            check($sformatf("latency_src%0d", src), {tx_tvalid, tx_tlast, tx_tdata},
                  {1'b1, src_last[src], pkt_bytes[src][i]});
            if (abort_after[src] == i + 1) begin
                rst            = 1'b1;
                src_valid[src] = 1'b0;
                src_last[src]  = 1'b0;
                return;
            end
            if (i == gap_at[src]) begin
                src_valid[src] = 1'b0;
                repeat (gap_len[src]) begin
                    @(negedge clk);
                    check($sformatf("gap_grant_src%0d", src), 32'(grant), 32'(1 << src));
                end
                @(posedge clk);
                #1;
            end
        end
        src_valid[src] = 1'b0;
        src_last[src]  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_tvalid) break;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("idle_busy", {busy, 4'(grant)}, 5'b0_0000);
    endtask

    // Monitor: compares every transferred beat and checks that stalled data holds.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid && tx_tvalid)
                    check("stall_hold", {tx_tlast, tx_tdata}, {held_last, held_data});
                if (tx_tvalid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL out_beat: unexpected beat %0h last=%0b", tx_tdata, tx_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {tx_tlast, tx_tdata}, {e.last, e.data});
                    end
                end
                held_valid = tx_tvalid && !tx_ready;
                held_data  = tx_tdata;
                held_last  = tx_tlast;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1;
        tx_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_valid[k] = 1'b0;
            src_last[k]  = 1'b0;
            src_data[k]  = 8'h00;
            gap_at[k]    = -1;
            gap_len[k]   = 0;
            abort_after[k] = -1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {tx_tvalid, tx_tlast, tx_tdata}, 10'd0);
        check("rst_grant_ready_busy", {4'(grant), 4'(src_tready), busy}, 9'd0);

        // Single packet from src1.
        do_reset();
        pkt_len[1] = 4;
        pkt_bytes[1][0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_pkt(1);
        run_src(1);
        wait_drain();

        // All four sources at once: strict round-robin from src0, no interleaving.
        do_reset();
        for (int k = 0; k < N; k++) begin
            pkt_len[k] = 2;
            pkt_bytes[k][0] = 8'(k * 16 + 1);
            pkt_bytes[k][1] = 8'(k * 16 + 2);
            push_pkt(k);
        end
        fork
            run_src(0);
            run_src(1);
            run_src(2);
            run_src(3);
        join
        wait_drain();

        // Back-pressure 1,0,0,1 during AA BB CC.
        do_reset();
        pkt_len[0] = 3;
        pkt_bytes[0][0:2] = '{8'hAA, 8'hBB, 8'hCC};
        push_pkt(0);
        fork
            run_src(0);
            begin
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (tx_tvalid) break;
                end
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1 tx_ready = pat[i];
                end
                @(posedge clk);
                #1 tx_ready = 1'b1;
            end
        join
        wait_drain();

        // src2 pauses 5 cycles mid-packet while src0 requests; grant must hold.
        do_reset();
        pkt_len[2] = 3;
        pkt_bytes[2][0:2] = '{8'h21, 8'h22, 8'h23};
        gap_at[2]  = 1;
        gap_len[2] = 5;
        pkt_len[0] = 2;
        pkt_bytes[0][0:1] = '{8'h01, 8'h02};
        push_pkt(2);
        push_pkt(0);
        fork
            run_src(2);
            begin
                repeat (3) @(posedge clk);
                #1;
                run_src(0);
            end
        join
        wait_drain();

        // Reset after byte 2 of a 4-byte packet; then src0 must win over src1.
        do_reset();
        pkt_len[0] = 2;
        pkt_bytes[0][0:1] = '{8'h01, 8'h02};
        push_pkt(0);
        run_src(0);
        wait_drain();
        pkt_len[2] = 4;
        pkt_bytes[2][0:3] = '{8'h51, 8'h52, 8'h53, 8'h54};
        abort_after[2] = 2;
        begin
            exp_t e;
`ifdef UDP_TX_ARB_HDR_EN
            e.data = HDR_BASE_DEF | 8'd2;
            e.last = 1'b0;
            exp_q.push_back(e);
`endif
            e.data = 8'h51;
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        run_src(2);
        #1;
        check("abort_outputs", {tx_tvalid, tx_tlast, tx_tdata}, 10'd0);
        check("abort_grant_ready_busy", {4'(grant), 4'(src_tready), busy}, 9'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        abort_after[2] = -1;
        pkt_len[0] = 2;
        pkt_bytes[0][0:1] = '{8'h61, 8'h62};
        pkt_len[1] = 2;
        pkt_bytes[1][0:1] = '{8'h71, 8'h72};
        push_pkt(0);
        push_pkt(1);
        fork
            run_src(0);
            run_src(1);
        join
        wait_drain();

        // src3 sends 01 02 (prefixed by A3 in header builds).
        do_reset();
        pkt_len[3] = 2;
        pkt_bytes[3][0:1] = '{8'h01, 8'h02};
        push_pkt(3);
        run_src(3);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
